// File: rtl/lsu_mem_stage_if.sv
// Bus bundle for the load/store memory stage: execute request, writeback response and RAM port.
// slave is the LSU's view; master is the view of whatever surrounds it.
interface lsu_mem_stage_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_is_store;
    logic [2:0]        req_funct3;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [4:0]        req_rd;

    logic              resp_valid;
    logic              resp_ready;
    logic [4:0]        resp_rd;
    logic [XLEN-1:0]   resp_data;
    logic              resp_err;

    logic              ram_read_flag;
    logic [ADDR_W-1:0] ram_read_addr;
    logic [XLEN-1:0]   ram_read_data;
    logic              ram_write_flag;
    logic [ADDR_W-1:0] ram_write_addr;
    logic [XLEN-1:0]   ram_write_data;
    logic [2:0]        ram_write_size;

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        input  resp_ready, ram_read_data,
        output req_ready, resp_valid, resp_rd, resp_data, resp_err,
        output ram_read_flag, ram_read_addr, ram_write_flag, ram_write_addr,
        output ram_write_data, ram_write_size
    );

    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        output resp_ready, ram_read_data,
        input  req_ready, resp_valid, resp_rd, resp_data, resp_err,
        input  ram_read_flag, ram_read_addr, ram_write_flag, ram_write_addr,
        input  ram_write_data, ram_write_size
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// Data-side load/store unit: validates one request at a time, drives the RAM port,
// extends load data and returns a tagged response to writeback.
module lsu_mem_stage #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned MEM_LAT = 1
) (
    input logic            clk,
    input logic            rst,
    lsu_mem_stage_if.slave bus
);
    localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE, S_RESP} state_t;

    state_t              r_state,       w_state_nx;
    logic [CNT_W-1:0]    r_cnt,         w_cnt_nx;
    logic [ADDR_W-1:0]   r_addr,        w_addr_nx;
    logic [XLEN-1:0]     r_wdata,       w_wdata_nx;
    logic [2:0]          r_funct3,      w_funct3_nx;
    logic                r_req_ready,   w_req_ready_nx;
    logic                r_rd_flag,     w_rd_flag_nx;
    logic                r_wr_flag,     w_wr_flag_nx;
    logic                r_resp_valid,  w_resp_valid_nx;
    logic [4:0]          r_resp_rd,     w_resp_rd_nx;
    logic [XLEN-1:0]     r_resp_data,   w_resp_data_nx;
    logic                r_resp_err,    w_resp_err_nx;

    logic [1:0]          w_size;
    logic                w_f3_bad;
    logic                w_misaligned;
    logic                w_out_of_range;
    logic                w_err;
    logic [XLEN-1:0]     w_ext;

    // Request validation, evaluated on the incoming (not yet latched) request
    always_comb begin
        w_size         = bus.req_funct3[1:0];
        w_f3_bad       = bus.req_is_store ? (bus.req_funct3[2] | (&w_size))
                                          : ((&w_size) | (bus.req_funct3 == 3'b110));
        w_misaligned   = ((w_size == 2'b01) && bus.req_addr[0]) ||
                         ((w_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
        w_out_of_range = |(bus.req_addr >> ADDR_W);
        w_err          = w_f3_bad | w_misaligned | w_out_of_range;
    end

    // Load data extraction from the little-endian RAM word
    always_comb begin
        case (r_funct3)
            3'b000:  w_ext = {{(XLEN-8){bus.ram_read_data[7]}},   bus.ram_read_data[7:0]};
            3'b001:  w_ext = {{(XLEN-16){bus.ram_read_data[15]}}, bus.ram_read_data[15:0]};
            3'b010:  w_ext = bus.ram_read_data;
            3'b100:  w_ext = {{(XLEN-8){1'b0}},  bus.ram_read_data[7:0]};
            3'b101:  w_ext = {{(XLEN-16){1'b0}}, bus.ram_read_data[15:0]};
            default: w_ext = '0;
        endcase
    end

    // Next-state and next-output logic; every output is registered from here
    always_comb begin
        w_state_nx      = r_state;
        w_cnt_nx        = r_cnt;
        w_addr_nx       = r_addr;
        w_wdata_nx      = r_wdata;
        w_funct3_nx     = r_funct3;
        w_req_ready_nx  = 1'b0;
        w_rd_flag_nx    = 1'b0;
        w_wr_flag_nx    = 1'b0;
        w_resp_valid_nx = r_resp_valid;
        w_resp_rd_nx    = r_resp_rd;
        w_resp_data_nx  = r_resp_data;
        w_resp_err_nx   = r_resp_err;

        case (r_state)
            S_IDLE: begin
                w_req_ready_nx = 1'b1;
                if (r_req_ready && bus.req_valid) begin
                    w_req_ready_nx = 1'b0;
                    w_addr_nx      = bus.req_addr[ADDR_W-1:0];
                    w_wdata_nx     = bus.req_wdata;
                    w_funct3_nx    = bus.req_funct3;
                    w_resp_rd_nx   = bus.req_is_store ? 5'd0 : bus.req_rd;
                    w_resp_data_nx = '0;
                    w_resp_err_nx  = 1'b0;
                    if (w_err) begin
                        w_state_nx      = S_RESP;
                        w_resp_valid_nx = 1'b1;
                        w_resp_err_nx   = 1'b1;
                    end else if (bus.req_is_store) begin
                        w_state_nx   = S_STORE;
                        w_wr_flag_nx = 1'b1;
                    end else begin
                        w_state_nx   = S_LOAD;
                        w_cnt_nx     = '0;
                        w_rd_flag_nx = 1'b1;
                    end
                end
            end
            S_STORE: begin
                w_state_nx      = S_RESP;
                w_resp_valid_nx = 1'b1;
            end
            S_LOAD: begin
                w_rd_flag_nx = 1'b1;
                w_cnt_nx     = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(MEM_LAT - 1)) begin
                    w_state_nx      = S_RESP;
                    w_rd_flag_nx    = 1'b0;
                    w_cnt_nx        = '0;
                    w_resp_valid_nx = 1'b1;
                    w_resp_data_nx  = w_ext;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    w_state_nx      = S_IDLE;
                    w_req_ready_nx  = 1'b1;
                    w_resp_valid_nx = 1'b0;
                    w_resp_rd_nx    = 5'd0;
                    w_resp_data_nx  = '0;
                    w_resp_err_nx   = 1'b0;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_funct3     <= '0;
            r_req_ready  <= 1'b0;
            r_rd_flag    <= 1'b0;
            r_wr_flag    <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rd    <= '0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_addr       <= w_addr_nx;
            r_wdata      <= w_wdata_nx;
            r_funct3     <= w_funct3_nx;
            r_req_ready  <= w_req_ready_nx;
            r_rd_flag    <= w_rd_flag_nx;
            r_wr_flag    <= w_wr_flag_nx;
            r_resp_valid <= w_resp_valid_nx;
            r_resp_rd    <= w_resp_rd_nx;
            r_resp_data  <= w_resp_data_nx;
            r_resp_err   <= w_resp_err_nx;
        end
    end

    assign bus.req_ready      = r_req_ready;
    assign bus.resp_valid     = r_resp_valid;
    assign bus.resp_rd        = r_resp_rd;
    assign bus.resp_data      = r_resp_data;
    assign bus.resp_err       = r_resp_err;
    assign bus.ram_read_flag  = r_rd_flag;
    assign bus.ram_read_addr  = r_addr;
    assign bus.ram_write_flag = r_wr_flag;
    assign bus.ram_write_addr = r_addr;
    assign bus.ram_write_data = r_wdata;
    // Write size encoding (B=0, H=1, W=2) matches store funct3 for legal stores
    assign bus.ram_write_size = r_funct3;
endmodule
